// File: rtl/io_hub_pkg.sv
// Shared constants for the io_hub peripheral: register offsets (relative to
// ROWS, since the back-buffer rows occupy offsets 0..ROWS-1), STATUS bit
// positions and the register-select type used by the address decoder.
package io_hub_pkg;

  // Control/status registers sit directly after the back-buffer rows.
  // Absolute offset of each register = ROWS + OFF_x.
  localparam int OFF_CTRL   = 0;
  localparam int OFF_STATUS = 1;
  localparam int OFF_EVT    = 2;
  localparam int OFF_LVL    = 3;

  // Number of registers following the back-buffer rows.
  localparam int NUM_CSR    = 4;

  // STATUS register bit positions.
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_PARITY_BIT  = 1;

  // CTRL register bit that requests a frame swap.
  localparam int CTRL_SWAP_BIT = 0;

  // Which register (if any) the current bus address selects.
  typedef enum logic [2:0] {
    REG_NONE   = 3'd0,
    REG_BACK   = 3'd1,
    REG_CTRL   = 3'd2,
    REG_STATUS = 3'd3,
    REG_EVT    = 3'd4,
    REG_LVL    = 3'd5
  } reg_sel_e;

endpackage

// File: rtl/io_hub_debounce.sv
// One button channel: two-flop synchroniser followed by a stability counter.
// The debounced level only moves after the synchronised input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreement in between
// restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);

  // Counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronise the raw level, then count consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level   <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      if (sync2_q != level) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/io_hub.sv
// Memory-mapped I/O hub: NUM_BTN debounced buttons with press-event latching,
// and a double-buffered ROWS x COLS LED matrix scanner. The CPU fills the
// back buffer and requests a swap; the copy to the front buffer happens only
// when the scan wraps to row 0, so a frame is never shown half old, half new.
module io_hub
  import io_hub_pkg::*;
#(
  parameter int         NUM_BTN         = 2,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         ROWS            = 8,
  parameter int         COLS            = 8,
  parameter int         SCAN_DIV        = 1000,
  parameter logic [7:0] IO_BASE         = 8'hF0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         addr,
  input  logic [7:0]         wdata,
  input  logic               we,
  input  logic               re,
  output logic [7:0]         rdata,
  input  logic [NUM_BTN-1:0] btn,
  output logic [ROWS-1:0]    led_row,
  output logic [COLS-1:0]    led_col
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  // Absolute offsets of the control/status registers inside the window.
  localparam logic [8:0] A_CTRL   = 9'(ROWS + OFF_CTRL);
  localparam logic [8:0] A_STATUS = 9'(ROWS + OFF_STATUS);
  localparam logic [8:0] A_EVT    = 9'(ROWS + OFF_EVT);
  localparam logic [8:0] A_LVL    = 9'(ROWS + OFF_LVL);
  localparam logic [8:0] A_ROWS   = 9'(ROWS);

  // Bus strobes: we and re are single-cycle qualifiers sampled on the rising
  // clk edge with addr/wdata; there is no back-pressure, every strobe is
  // accepted in the cycle it is seen. A read returns the register contents
  // from before that edge on rdata one cycle later, and rdata holds until
  // the next read. With we and re together, the read sees pre-write data.

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [8:0]       off;
  logic [ROW_W-1:0] back_idx;
  reg_sel_e         sel;

  // Nine-bit subtraction: an address below IO_BASE borrows into bit 8 and
  // therefore lands far outside the window.
  assign off      = {1'b0, addr} - {1'b0, IO_BASE};
  assign back_idx = off[ROW_W-1:0];

  // Map the offset onto a register select.
  always_comb begin
    sel = REG_NONE;
    if (off < A_ROWS)          sel = REG_BACK;
    else if (off == A_CTRL)    sel = REG_CTRL;
    else if (off == A_STATUS)  sel = REG_STATUS;
    else if (off == A_EVT)     sel = REG_EVT;
    else if (off == A_LVL)     sel = REG_LVL;
  end

  // ---------------------------------------------------------------------
  // Button channels
  // ---------------------------------------------------------------------
  logic [NUM_BTN-1:0] lvl;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[i]),
      .level(lvl[i])
    );
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [COLS-1:0]    back_q  [ROWS];
  logic [COLS-1:0]    front_q [ROWS];
  logic               pending_q;
  logic               parity_q;
  logic [NUM_BTN-1:0] evt_q;
  logic [NUM_BTN-1:0] lvl_prev_q;
  logic [DIV_W-1:0]   div_q;
  logic [ROW_W-1:0]   row_q;

  // ---------------------------------------------------------------------
  // Scanner next state
  // ---------------------------------------------------------------------
  logic             div_end;
  logic             row_end;
  logic             swap;
  logic [ROW_W-1:0] row_nxt;
  logic [ROWS-1:0]  led_row_nxt;
  logic [COLS-1:0]  led_col_nxt;

  // Advance the row on divider terminal count; the swap rides on the wrap.
  always_comb begin
    div_end = (div_q == DIV_W'(SCAN_DIV - 1));
    row_end = (row_q == ROW_W'(ROWS - 1));
    swap    = div_end && row_end && pending_q;
    row_nxt = row_q;
    if (div_end) begin
      row_nxt = row_end ? '0 : row_q + 1'b1;
    end
    led_row_nxt          = '0;
    led_row_nxt[row_nxt] = 1'b1;
    // On a swap the front buffer is being overwritten this very edge, so the
    // new row-0 data comes straight from the back buffer.
    led_col_nxt = swap ? back_q[0] : front_q[row_nxt];
  end

  // ---------------------------------------------------------------------
  // Bus-side next state
  // ---------------------------------------------------------------------
  logic               back_we;
  logic               ctrl_set;
  logic               evt_rd;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] evt_nxt;
  logic               pending_nxt;
  logic [7:0]         rd_val;

  // Decode strobes, event set/clear and the read mux.
  always_comb begin
    back_we     = we && (sel == REG_BACK);
    ctrl_set    = we && (sel == REG_CTRL) && wdata[CTRL_SWAP_BIT];
    evt_rd      = re && (sel == REG_EVT);
    rise        = lvl & ~lvl_prev_q;
    // Clear only what this read returns; a same-cycle press survives.
    evt_nxt     = (evt_q & ~({NUM_BTN{evt_rd}} & evt_q)) | rise;
    // A CTRL write landing on the swap edge re-arms the next frame.
    pending_nxt = (pending_q & ~swap) | ctrl_set;
    rd_val      = '0;
    case (sel)
      REG_STATUS: begin
        rd_val[STATUS_PENDING_BIT] = pending_q;
        rd_val[STATUS_PARITY_BIT]  = parity_q;
      end
      REG_EVT: rd_val[NUM_BTN-1:0] = evt_q;
      REG_LVL: rd_val[NUM_BTN-1:0] = lvl;
      default: rd_val = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------

  // Row divider, row index and the registered LED drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      row_q   <= '0;
      led_row <= '0;
      led_col <= '0;
    end else begin
      div_q   <= div_end ? '0 : div_q + 1'b1;
      row_q   <= row_nxt;
      led_row <= led_row_nxt;
      led_col <= led_col_nxt;
    end
  end

  // Back buffer takes CPU writes; front buffer takes a full copy on swap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        back_q[r]  <= '0;
        front_q[r] <= '0;
      end
    end else begin
      if (swap) begin
        for (int r = 0; r < ROWS; r++) begin
          front_q[r] <= back_q[r];
        end
      end
      if (back_we) begin
        back_q[back_idx] <= wdata[COLS-1:0];
      end
    end
  end

  // Swap request flag and frame parity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      pending_q <= pending_nxt;
      if (swap) begin
        parity_q <= ~parity_q;
      end
    end
  end

  // Latched press events and the previous debounced level for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_q      <= '0;
      lvl_prev_q <= '0;
    end else begin
      evt_q      <= evt_nxt;
      lvl_prev_q <= lvl;
    end
  end

  // Registered read data, updated only by a read strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_val;
    end
  end

endmodule
